user_id_reader: RTL

USER_ID_READER -- requirements
Module: user_id_reader

---
 rtl/user_id_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/user_id_reader.sv
// Shadows a tie-cell user ID into registers, exposes a checksum and a word read port.
// Define USER_ID_SERIAL_EN to add the MSB-first serial readout of all captured words.
`timescale 1ns/1ps

module user_id_reader #(
    parameter int NUM_WORDS = 2,
    parameter int ADDR_W    = 3
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    input  logic [NUM_WORDS*32-1:0] id_raw,
    input  logic                   recapture,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_ack,
    output logic [31:0]            rd_data,
    output logic                   rd_err,
    output logic                   ready,
    output logic [31:0]            checksum,
    input  logic                   ser_start,
    output logic                   ser_out,
    output logic                   ser_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W:0]   NW_LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic {
        S_CAPTURE,
        S_READY
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_index;
    logic [31:0]       r_shadow [NUM_WORDS];
    logic [31:0]       r_checksum;
    logic              w_ready;
    logic              w_capture_en;
    logic              w_last_word;
    logic              w_accept;
    logic              w_addr_ok;
    logic [31:0]       w_cap_word;
    logic [31:0]       w_rd_word;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (recapture) begin
            w_next_state = S_CAPTURE;
        end else if (r_state == S_CAPTURE && w_last_word) begin
            w_next_state = S_READY;
        end
    end

    always_comb begin
        w_ready      = (r_state == S_READY);
        w_capture_en = (r_state == S_CAPTURE) && !recapture;
    end

    assign w_last_word = (r_index == LAST_IDX);
    assign w_addr_ok   = ({1'b0, rd_addr} < NW_LIMIT);
    assign w_accept    = rd_req && w_ready && !rd_ack && !recapture;

    // Explicit compare loops keep out-of-range addresses from indexing past the array.
    always_comb begin
        w_cap_word = '0;
        w_rd_word  = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_index == ADDR_W'(k)) begin
                w_cap_word = id_raw[32*k +: 32];
            end
            if (rd_addr == ADDR_W'(k)) begin
                w_rd_word = r_shadow[k];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_index    <= '0;
            r_checksum <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (recapture) begin
            r_index    <= '0;
            r_checksum <= '0;
        end else if (w_capture_en) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (r_index == ADDR_W'(k)) begin
                    r_shadow[k] <= id_raw[32*k +: 32];
                end
            end
            r_checksum <= r_checksum ^ w_cap_word;
            r_index    <= w_last_word ? '0 : r_index + ADDR_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_ack <= w_accept;
            if (w_accept) begin
                rd_data <= w_addr_ok ? w_rd_word : '0;
                rd_err  <= !w_addr_ok;
            end
        end
    end

    assign ready    = w_ready;
    assign checksum = r_checksum;

`ifdef USER_ID_SERIAL_EN
    localparam int                SER_BITS = NUM_WORDS * 32;
    localparam int                SER_CW   = $clog2(SER_BITS + 1);
    localparam logic [SER_CW-1:0] SER_DONE = SER_CW'(SER_BITS);

    logic [SER_BITS-1:0] r_ser_sh;
    logic [SER_BITS-1:0] w_ser_load;
    logic [SER_CW-1:0]   r_ser_cnt;
    logic                r_ser_busy;
    logic                r_ser_out;
    logic                w_ser_accept;

    // Word 0 sits at the top so a plain left shift emits it first, MSB first.
    always_comb begin
        w_ser_load = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_ser_load[SER_BITS-32-32*k +: 32] = r_shadow[k];
        end
    end

    assign w_ser_accept = ser_start && w_ready && !r_ser_busy && !recapture;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ser_sh   <= '0;
            r_ser_cnt  <= '0;
            r_ser_busy <= 1'b0;
            r_ser_out  <= 1'b0;
        end else if (recapture) begin
            r_ser_sh   <= '0;
            r_ser_cnt  <= '0;
            r_ser_busy <= 1'b0;
            r_ser_out  <= 1'b0;
        end else if (w_ser_accept) begin
            r_ser_sh   <= w_ser_load << 1;
            r_ser_cnt  <= SER_CW'(1);
            r_ser_busy <= 1'b1;
            r_ser_out  <= w_ser_load[SER_BITS-1];
        end else if (r_ser_busy) begin
            if (r_ser_cnt == SER_DONE) begin
                r_ser_cnt  <= '0;
                r_ser_busy <= 1'b0;
                r_ser_out  <= 1'b0;
            end else begin
                r_ser_sh  <= r_ser_sh << 1;
                r_ser_cnt <= r_ser_cnt + SER_CW'(1);
                r_ser_out <= r_ser_sh[SER_BITS-1];
            end
        end
    end

    assign ser_out  = r_ser_out;
    assign ser_busy = r_ser_busy;
`else
    logic w_ser_start_unused;

    assign w_ser_start_unused = ser_start;
    assign ser_out            = 1'b0;
    assign ser_busy           = 1'b0;
`endif

endmodule
